// File: rtl/stepper_move_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl
//
// Purpose:
//   Command stage that sits in front of the stepper phase sequencer. It takes
//   move commands (step count + direction) over a valid/ready handshake. It
//   presents the direction to the sequencer for a settle interval. It then
//   holds the enable level high for exactly the commanded number of step
//   periods, with one strobe per completed step, and pulses done at the end.
//
// Ports:
//   CLK50MHZ                 in   1      system clock
//   RESETN                   in   1      synchronous active-low reset
//   cmd_valid                in   1      move command present
//   cmd_ready                out  1      command can be accepted (IDLE only)
//   cmd_steps                in   CNT_W  number of steps to move (0 legal)
//   cmd_dir                  in   1      requested direction
//   abort                    in   1      stop the current move immediately
//   motorEnable              out  1      enable level to the sequencer
//   rotationDirectionChange  out  1      direction level to the sequencer
//   step_strobe              out  1      1-cycle pulse at end of each step period
//   busy                     out  1      high while a move is in progress
//   done                     out  1      1-cycle pulse when a move ends
//   aborted                  out  1      last move was ended by abort
//   steps_remaining          out  CNT_W  steps left in the current move
// -----------------------------------------------------------------------------
module stepper_move_ctrl #(
  parameter int unsigned STEP_PERIOD  = 1000002,
  parameter int unsigned SETUP_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK50MHZ,
  input  logic             RESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic             motorEnable,
  output logic             rotationDirectionChange,
  output logic             step_strobe,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_remaining
);

  // Counter widths, kept at least one bit wide for degenerate parameters.
  localparam int unsigned PW = (STEP_PERIOD  > 1) ? $clog2(STEP_PERIOD)  : 1;
  localparam int unsigned SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(STEP_PERIOD - 1);
  localparam logic [SW-1:0] SETUP_LAST  = SW'(SETUP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [PW-1:0]     period_q,    period_d;
  logic [SW-1:0]     setup_q,     setup_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              dir_q,       dir_d;
  logic              aborted_q,   aborted_d;
  logic              strobe_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK50MHZ) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      period_q    <= '0;
      setup_q     <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      setup_q     <= setup_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      aborted_q   <= aborted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    setup_d     = setup_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    aborted_d   = aborted_q;
    strobe_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          aborted_d   = 1'b0;
          // A zero-step move reports zero remaining and skips straight to DONE
          // without touching the direction level.
          remaining_d = cmd_steps;
          period_d    = '0;
          setup_d     = '0;
          if (cmd_steps == '0) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            dir_d   = cmd_dir;
          end
        end
      end

      SETUP: begin
        // Direction settles with the enable low before the run starts.
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (setup_q == SETUP_LAST) begin
          state_d  = RUN;
          period_d = '0;
        end else begin
          setup_d = setup_q + 1'b1;
        end
      end

      RUN: begin
        // Abort takes priority over a step completing in the same cycle, so
        // the count stays frozen and no strobe is emitted.
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (period_q == PERIOD_LAST) begin
          strobe_d = 1'b1;
          period_d = '0;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
          end
          if (remaining_q <= CNT_W'(1)) begin
            state_d = DONE;
          end
        end else begin
          period_d = period_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready               = (state_q == IDLE);
  assign motorEnable             = (state_q == RUN);
  assign busy                    = (state_q != IDLE);
  assign done                    = (state_q == DONE);
  assign step_strobe             = strobe_d;
  assign rotationDirectionChange = dir_q;
  assign aborted                 = aborted_q;
  assign steps_remaining         = remaining_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_move_ctrl
//
// Bench for stepper_move_ctrl with STEP_PERIOD=4, SETUP_CYCLES=2. A move is
// modelled as a timeline: k cycles after acceptance, the enable level, strobe
// and remaining count follow directly from k, N, SETUP and PERIOD. Directed
// scenarios pin that model with hand-computed literals, and a randomized run
// follows them.
// -----------------------------------------------------------------------------
module tb_stepper_move_ctrl;

  localparam int P     = 4;
  localparam int S     = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             RESETN;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic             abort;
  logic             motorEnable;
  logic             rotationDirectionChange;
  logic             step_strobe;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_remaining;

  stepper_move_ctrl #(
    .STEP_PERIOD (P),
    .SETUP_CYCLES(S),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK50MHZ               (clk),
    .RESETN                 (RESETN),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_steps              (cmd_steps),
    .cmd_dir                (cmd_dir),
    .abort                  (abort),
    .motorEnable            (motorEnable),
    .rotationDirectionChange(rotationDirectionChange),
    .step_strobe            (step_strobe),
    .busy                   (busy),
    .done                   (done),
    .aborted                (aborted),
    .steps_remaining        (steps_remaining)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle compare
  // ---------------------------------------------------------------------------
  bit m_move, m_done, m_dir, m_ab;
  int m_k, m_n, m_rem;
  int e_en, e_strobe, e_rem;

  int cyc = 0, en_cnt = 0, strobe_cnt = 0, last_strobe_cyc = 0, last_gap = 0;
  logic prev_dir = 1'b0, prev_en = 1'b0, last_rstn = 1'b0;

  initial begin
    m_move = 0; m_done = 0; m_dir = 0; m_ab = 0; m_k = 0; m_n = 0; m_rem = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      e_en     = (m_move && m_k >= S) ? 1 : 0;
      e_strobe = (e_en == 1 && ((m_k - S) % P) == P - 1 && abort == 1'b0) ? 1 : 0;
      e_rem    = m_move ? ((m_k < S) ? m_n : m_n - (m_k - S) / P) : m_rem;

      chk("motorEnable", int'(motorEnable), e_en);
      chk("step_strobe", int'(step_strobe), e_strobe);
      chk("steps_remaining", int'(steps_remaining), e_rem);
      chk("done", int'(done), int'(m_done));
      chk("busy", int'(busy), int'(m_move | m_done));
      chk("cmd_ready", int'(cmd_ready), int'(!(m_move | m_done)));
      chk("aborted", int'(aborted), int'(m_ab));
      chk("dir", int'(rotationDirectionChange), int'(m_dir));

      if (motorEnable === 1'b1) en_cnt++;
      if (step_strobe === 1'b1) begin
        last_gap        = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
        strobe_cnt++;
      end
      // Direction may only move while the enable is low on both sides.
      if (last_rstn === 1'b1 && rotationDirectionChange !== prev_dir)
        chk("dir_change_while_enabled", int'({prev_en, motorEnable}), 0);
      prev_dir  = rotationDirectionChange;
      prev_en   = motorEnable;
      last_rstn = RESETN;

      // Advance the model to the next edge.
      if (!RESETN) begin
        m_move = 0; m_done = 0; m_dir = 0; m_ab = 0; m_k = 0; m_rem = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_move) begin
        if (abort) begin
          m_move = 0; m_done = 1; m_ab = 1; m_rem = e_rem;
        end else if (m_k == S + m_n * P - 1) begin
          m_move = 0; m_done = 1; m_rem = 0;
        end else begin
          m_k++;
        end
      end else if (cmd_valid) begin
        m_ab  = 0;
        m_rem = int'(cmd_steps);
        if (cmd_steps == '0) begin
          m_done = 1;
        end else begin
          m_move = 1; m_k = 0; m_n = int'(cmd_steps); m_dir = cmd_dir;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("wait_done_reached", int'(done), 1);
  endtask

  task automatic accept(input int steps, input bit dir);
    cmd_valid = 1'b1;
    cmd_steps = CNT_W'(steps);
    cmd_dir   = dir;
    step();
    cmd_valid = 1'b0;
  endtask

  int n, e0, s0;

  initial begin
    RESETN = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; abort = 1'b0;
    repeat (3) step();
    RESETN = 1'b1;
    chk("rst_enable", int'(motorEnable), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_remaining", int'(steps_remaining), 0);
    step();

    // 3-step move, direction 1
    accept(3, 1'b1);
    e0 = en_cnt; s0 = strobe_cnt;
    chk("m3_dir_next_edge", int'(rotationDirectionChange), 1);
    chk("m3_enable_in_setup", int'(motorEnable), 0);
    wait_done(n);
    chk("m3_cycles_to_done", n, 14);
    chk("m3_enable_cycles", en_cnt - e0, 12);
    chk("m3_strobes", strobe_cnt - s0, 3);
    chk("m3_strobe_gap", last_gap, 4);
    chk("m3_aborted", int'(aborted), 0);
    chk("m3_remaining", int'(steps_remaining), 0);
    step();
    chk("m3_idle_done", int'(done), 0);
    chk("m3_idle_ready", int'(cmd_ready), 1);

    // zero-step move
    accept(0, 1'b0);
    chk("m0_done", int'(done), 1);
    chk("m0_busy", int'(busy), 1);
    chk("m0_dir_unchanged", int'(rotationDirectionChange), 1);
    chk("m0_enable", int'(motorEnable), 0);
    step();
    chk("m0_busy_after", int'(busy), 0);

    // abort in the 2nd step of a 5-step move
    accept(5, 1'b0);
    s0 = strobe_cnt;
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab5_done", int'(done), 1);
    chk("ab5_aborted", int'(aborted), 1);
    chk("ab5_remaining", int'(steps_remaining), 4);
    chk("ab5_enable", int'(motorEnable), 0);
    chk("ab5_strobes", strobe_cnt - s0, 1);
    step();

    // abort exactly on a strobe cycle
    accept(3, 1'b1);
    s0 = strobe_cnt;
    repeat (5) step();
    abort = 1'b1;
    #1;
    chk("abs_no_strobe", int'(step_strobe), 0);
    step();
    abort = 1'b0;
    chk("abs_done", int'(done), 1);
    chk("abs_aborted", int'(aborted), 1);
    chk("abs_remaining", int'(steps_remaining), 3);
    chk("abs_strobes", strobe_cnt - s0, 0);
    step();

    // back-to-back with cmd_valid held high
    accept(1, 1'b0);
    cmd_valid = 1'b1; cmd_steps = CNT_W'(2); cmd_dir = 1'b1;
    chk("b2b_ready_busy", int'(cmd_ready), 0);
    wait_done(n);
    chk("b2b_first_len", n, 6);
    chk("b2b_ready_in_done", int'(cmd_ready), 0);
    step();
    chk("b2b_ready_idle", int'(cmd_ready), 1);
    chk("b2b_dir_hold", int'(rotationDirectionChange), 0);
    step();
    cmd_valid = 1'b0;
    chk("b2b_second_busy", int'(busy), 1);
    chk("b2b_second_dir", int'(rotationDirectionChange), 1);
    chk("b2b_second_rem", int'(steps_remaining), 2);
    chk("b2b_second_enable", int'(motorEnable), 0);
    wait_done(n);
    chk("b2b_aborted", int'(aborted), 0);
    step();

    // reset in the middle of RUN
    accept(4, 1'b1);
    repeat (5) step();
    chk("rr_enable_run", int'(motorEnable), 1);
    RESETN = 1'b0;
    step();
    step();
    chk("rr_enable", int'(motorEnable), 0);
    chk("rr_busy", int'(busy), 0);
    chk("rr_ready", int'(cmd_ready), 1);
    chk("rr_remaining", int'(steps_remaining), 0);
    RESETN = 1'b1;
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_steps = CNT_W'($urandom_range(0, 4));
      cmd_dir   = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 24) == 0);
      RESETN    = ($urandom_range(0, 299) != 0);
      step();
    end
    cmd_valid = 1'b0; abort = 1'b0; RESETN = 1'b1;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
